key_pattern_gen: RTL

Generates the stimulus side of the key-hit game: the 26-bit beat counter `cnt`, the one-hot target key `key_random`, and the `finish` flag consumed by the key judge. The judge compares `key` against `key_random` at `cnt==3900000` (hit) and `cnt==2000000` (miss) while `finish==0`. This block owns the round sequencing: start detection, beat timing, pseudo-random key selection, and end-of-game.

---
 rtl/key_game_pkg.sv | 30 +++
 rtl/key_lfsr.sv | 35 +++
 rtl/key_pattern_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/key_game_pkg.sv
// Shared types and constants for the key-hit game blocks.
package key_game_pkg;

  localparam int CNT_W  = 26;
  localparam int KEY_W  = 4;
  localparam int LFSR_W = 8;
  localparam int RND_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Judge sample points within a round
  localparam logic [CNT_W-1:0] HIT_AT     = 26'd3900000;
  localparam logic [CNT_W-1:0] MISS_AT    = 26'd2000000;
  localparam logic [CNT_W-1:0] PERIOD_DEF = 26'd4000000;
  localparam logic [RND_W-1:0] ROUNDS_DEF = 6'd30;
  localparam logic [LFSR_W-1:0] SEED_DEF  = 8'hA5;

  function automatic logic [KEY_W-1:0] key_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  function automatic logic [KEY_W-1:0] key_rotl(input logic [KEY_W-1:0] k);
    return {k[KEY_W-2:0], k[KEY_W-1]};
  endfunction

endpackage

// File: rtl/key_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing only on step, with the
// one-hot key derived from its two low bits.
module key_lfsr
  import key_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [KEY_W-1:0] key_raw
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
    key_raw = key_onehot(lfsr_q[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/key_pattern_gen.sv
// Round sequencer for the key-hit game: beat counter, target key, finish flag.
// Optional KEY_NOREPEAT_EN forbids the same key in consecutive rounds.
module key_pattern_gen
  import key_game_pkg::*;
#(
  parameter logic [CNT_W-1:0]  PERIOD = PERIOD_DEF,
  parameter logic [RND_W-1:0]  ROUNDS = ROUNDS_DEF,
  parameter logic [LFSR_W-1:0] SEED   = SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [CNT_W-1:0] cnt,
  output logic [KEY_W-1:0] key_random,
  output logic             finish,
  output logic [RND_W-1:0] round
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             finish_q, finish_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             start_d_q, start_d_d;
  logic             seen_low_q, seen_low_d;
  logic             start_edge_q, start_edge_d;
  logic             lfsr_step;
  logic [KEY_W-1:0] key_raw;
  logic [KEY_W-1:0] key_next;

  key_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (lfsr_step),
    .key_raw(key_raw)
  );

`ifdef KEY_NOREPEAT_EN
  logic [KEY_W-1:0] key_prev;

  // Outside PLAY key_q is always zero, so a game's first key never rotates
  always_comb begin
    key_prev = (state_q == PLAY) ? key_q : '0;
    key_next = (key_raw == key_prev) ? key_rotl(key_raw) : key_raw;
  end
`else
  always_comb begin
    key_next = key_raw;
  end
`endif

  // A level held through reset must drop once before it can start a game
  always_comb begin
    start_d_d    = start;
    seen_low_d   = seen_low_q | ~start;
    start_edge_d = start & ~start_d_q & seen_low_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    finish_d  = finish_q;
    round_d   = round_q;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_edge_q) begin
          state_d   = PLAY;
          cnt_d     = '0;
          round_d   = '0;
          finish_d  = 1'b0;
          key_d     = key_next;
          lfsr_step = 1'b1;
        end
      end
      PLAY: begin
        if (cnt_q == PERIOD - 26'd1) begin
          cnt_d = '0;
          if (round_q < ROUNDS - 6'd1) begin
            round_d   = round_q + 6'd1;
            key_d     = key_next;
            lfsr_step = 1'b1;
          end else begin
            state_d  = DONE;
            key_d    = '0;
            finish_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        key_d    = '0;
        finish_d = 1'b1;
        round_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      finish_q     <= 1'b1;
      round_q      <= '0;
      start_d_q    <= 1'b0;
      seen_low_q   <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      finish_q     <= finish_d;
      round_q      <= round_d;
      start_d_q    <= start_d_d;
      seen_low_q   <= seen_low_d;
      start_edge_q <= start_edge_d;
    end
  end

  assign cnt        = cnt_q;
  assign key_random = key_q;
  assign finish     = finish_q;
  assign round      = round_q;

endmodule
